// File: rtl/noc_mining_pkg.sv
// Shared definitions for the mining NoC endpoints: result tags, FSM state codes
// and the FOUND-packet recogniser.
package noc_mining_pkg;

  localparam logic [15:0] RESULT_TAG = 16'hF0D0;
  localparam logic [31:0] FOUND_CODE = 32'h0000_0001;

  localparam logic [2:0] ST_IDLE        = 3'd0;
  localparam logic [2:0] ST_SEND        = 3'd1;
  localparam logic [2:0] ST_WAIT_RESULT = 3'd2;
  localparam logic [2:0] ST_RX_NONCE    = 3'd3;
  localparam logic [2:0] ST_RX_CLKS     = 3'd4;
  localparam logic [2:0] ST_DONE        = 3'd5;

  // First result flit: tag in [63:48], source miner in [47:32], FOUND in [31:0].
  function automatic logic is_found(input logic [63:0] word);
    return (word[63:48] == RESULT_TAG) && (word[31:0] == FOUND_CODE);
  endfunction

endpackage

// File: rtl/noc_credit_counter.sv
// Credit counter for one virtual channel: starts full, saturates at BUF_DEPTH,
// and leaves the count unchanged when a credit and a send coincide.
module noc_credit_counter #(
  parameter int unsigned BUF_DEPTH = 16
) (
  input  logic sys_clk,
  input  logic reset,
  input  logic inc,
  input  logic dec,
  output logic has_credit
);

  localparam int unsigned CW = $clog2(BUF_DEPTH + 1);

  logic [CW-1:0] count;

  always_ff @(posedge sys_clk) begin
    if (reset) begin
      count <= CW'(BUF_DEPTH);
    end else if (inc && !dec) begin
      if (count != CW'(BUF_DEPTH)) count <= count + CW'(1);
    end else if (dec && !inc) begin
      if (count != '0) count <= count - CW'(1);
    end
  end

  assign has_credit = (count != '0);

endmodule

// File: rtl/noc_mining_dispatcher.sv
// Host-side mining endpoint: unicasts the header to every miner with a per-miner
// starting nonce, then collects the 3-flit result packet or times out.
module noc_mining_dispatcher
  import noc_mining_pkg::*;
#(
  parameter int unsigned FLIT_DATA_WIDTH = 64,
  parameter int unsigned HEADER_WIDTH    = 640,
  parameter int unsigned NUM_MINERS      = 24,
  parameter int unsigned DEST_BITS       = 5,
  parameter int unsigned VC_BITS         = 2,
  parameter int unsigned TX_VC           = 0,
  parameter int unsigned BUF_DEPTH       = 16,
  parameter logic [31:0] NONCE_STRIDE    = 32'h0AAA_AAAA,
  parameter int unsigned TIMEOUT_CYCLES  = 0
) (
  input  logic                                        sys_clk,
  input  logic                                        reset,
  input  logic                                        start,
  input  logic [HEADER_WIDTH-1:0]                     header,
  output logic                                        busy,
  output logic                                        done,
  output logic                                        timed_out,
  output logic [DEST_BITS-1:0]                        winner,
  output logic [31:0]                                 nonce,
  output logic [63:0]                                 clk_cnt,
  output logic [2+FLIT_DATA_WIDTH+DEST_BITS+VC_BITS-1:0] putFlit,
  output logic                                        EN_putFlit,
  input  logic [VC_BITS:0]                            getCredits,
  output logic                                        EN_getCredits,
  input  logic [2+FLIT_DATA_WIDTH+DEST_BITS+VC_BITS-1:0] getFlit,
  output logic                                        EN_getFlit,
  output logic [VC_BITS:0]                            putCredits,
  output logic                                        EN_putCredits
);

  localparam int unsigned HDR_FLITS = HEADER_WIDTH / FLIT_DATA_WIDTH;
  localparam int unsigned KW        = (HDR_FLITS > 1) ? $clog2(HDR_FLITS) : 1;
  localparam int unsigned TW        = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int unsigned TMO_LAST  = (TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1;
  localparam int unsigned VALID_OFF = FLIT_DATA_WIDTH + VC_BITS + DEST_BITS + 1;

  logic [2:0]                                state;
  logic [HDR_FLITS-1:0][FLIT_DATA_WIDTH-1:0] hdr_q;
  logic [KW-1:0]                             flit_idx;
  logic [DEST_BITS-1:0]                      dest_idx;
  logic [TW-1:0]                             tmo_cnt;

  logic                       rx_valid, accept_found, credit_in, has_credit, send;
  logic                       last_flit, last_dest, start_ok;
  logic [63:0]                rx_word;
  logic [31:0]                nonce_base;
  logic [FLIT_DATA_WIDTH-1:0] tx_data;
  logic                       unused_rx;

  assign rx_valid     = getFlit[VALID_OFF];
  assign rx_word      = getFlit[63:0];
  assign unused_rx    = ^getFlit[VALID_OFF-1:64];
  assign accept_found = rx_valid && is_found(rx_word) &&
                        (state == ST_SEND || state == ST_WAIT_RESULT);
  assign credit_in    = getCredits[VC_BITS] && (getCredits[VC_BITS-1:0] == VC_BITS'(TX_VC));
  // A FOUND arriving during dispatch suppresses this cycle's send so nothing follows it.
  assign send         = (state == ST_SEND) && has_credit && !accept_found;
  assign last_flit    = (flit_idx == KW'(HDR_FLITS - 1));
  assign last_dest    = (dest_idx == DEST_BITS'(NUM_MINERS));
  assign start_ok     = start && (state == ST_IDLE || state == ST_DONE);
  assign nonce_base   = (32'(dest_idx) - 32'd1) * NONCE_STRIDE;

  always_comb begin
    tx_data = hdr_q[flit_idx];
    if (flit_idx == '0) tx_data[31:0] = nonce_base;
  end

  noc_credit_counter #(.BUF_DEPTH(BUF_DEPTH)) u_credits (
    .sys_clk    (sys_clk),
    .reset      (reset),
    .inc        (credit_in),
    .dec        (send),
    .has_credit (has_credit)
  );

  always_ff @(posedge sys_clk) begin
    if (reset) begin
      state         <= ST_IDLE;
      hdr_q         <= '0;
      flit_idx      <= '0;
      dest_idx      <= '0;
      tmo_cnt       <= '0;
      putFlit       <= '0;
      EN_putFlit    <= 1'b0;
      putCredits    <= '0;
      EN_putCredits <= 1'b0;
      winner        <= '0;
      nonce         <= '0;
      clk_cnt       <= '0;
      timed_out     <= 1'b0;
    end else begin
      EN_putFlit    <= send;
      putFlit       <= send ? {1'b1, last_flit, dest_idx, VC_BITS'(TX_VC), tx_data} : '0;
      EN_putCredits <= rx_valid && (state != ST_IDLE);
      putCredits    <= (rx_valid && state != ST_IDLE) ? {1'b1, VC_BITS'(TX_VC)} : '0;

      case (state)
        ST_IDLE, ST_DONE: begin
          if (start_ok) begin
            hdr_q     <= header;
            flit_idx  <= '0;
            dest_idx  <= DEST_BITS'(1);
            winner    <= '0;
            nonce     <= '0;
            clk_cnt   <= '0;
            timed_out <= 1'b0;
            state     <= ST_SEND;
          end
        end
        ST_SEND: begin
          if (accept_found) begin
            winner <= rx_word[32 +: DEST_BITS];
            state  <= ST_RX_NONCE;
          end else if (send) begin
            if (last_flit) begin
              flit_idx <= '0;
              if (last_dest) begin
                tmo_cnt <= '0;
                state   <= ST_WAIT_RESULT;
              end else begin
                dest_idx <= dest_idx + DEST_BITS'(1);
              end
            end else begin
              flit_idx <= flit_idx + KW'(1);
            end
          end
        end
        ST_WAIT_RESULT: begin
          if (accept_found) begin
            winner <= rx_word[32 +: DEST_BITS];
            state  <= ST_RX_NONCE;
          end else if (TIMEOUT_CYCLES != 0 && tmo_cnt == TW'(TMO_LAST)) begin
            winner    <= '0;
            nonce     <= '0;
            clk_cnt   <= '0;
            timed_out <= 1'b1;
            state     <= ST_DONE;
          end else begin
            tmo_cnt <= tmo_cnt + TW'(1);
          end
        end
        ST_RX_NONCE: begin
          if (rx_valid) begin
            nonce <= rx_word[31:0];
            state <= ST_RX_CLKS;
          end
        end
        ST_RX_CLKS: begin
          if (rx_valid) begin
            clk_cnt <= rx_word;
            state   <= ST_DONE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign busy          = (state == ST_SEND) || (state == ST_WAIT_RESULT) ||
                         (state == ST_RX_NONCE) || (state == ST_RX_CLKS);
  assign done          = (state == ST_DONE);
  assign EN_getCredits = 1'b1;
  assign EN_getFlit    = 1'b1;

endmodule
